fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Instruction prefetch queue directly downstream of the program counter and instruction memory.
- Buffers {PC, instruction} pairs produced by the fetch side and hands them to decode with a valid/ready handshake.
- Back-pressures the PC through InReady when full; discards all queued fetches on a branch/jump redirect (Flush).

Parameters:
DEPTH, 4, number of entries; must be a power of 2, minimum 2
AW, 2, pointer width; must equal log2(DEPTH)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
Flush  input  1  synchronous redirect; empties the queue
InValid  input  1  fetch side presents a valid PC/instruction pair
InPC  input  32  PC of the fetched instruction
InInstr  input  32  fetched instruction word
InReady  output  1  queue can accept an entry this cycle
OutValid  output  1  head entry is valid
OutPC  output  32  PC of head entry
OutInstr  output  32  instruction of head entry
OutMisaligned  output  1  head entry PC[1:0] != 0
OutReady  input  1  decode consumes the head entry this cycle
Count  output  AW+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (Reset, asynchronous, active-high; clock Clk): read/write pointers = 0, Count = 0, OutValid = 0, InReady = 1. Storage contents are don't-care.
- Push: occurs when InValid && InReady at a rising Clk edge. Writes {InPC, InInstr, InPC[1:0]!=0} at the write pointer, then increments it (mod DEPTH).
- Pop: occurs when OutValid && OutReady at a rising Clk edge. Increments the read pointer (mod DEPTH).
- InReady = (Count < DEPTH), registered-state only. No combinational path from OutReady. When full, a same-cycle pop does not enable a push.
- OutValid = (Count != 0). OutPC, OutInstr and OutMisaligned are first-word-fall-through from the head entry. When Count == 0 they are forced to 0.
- Latency: an entry pushed at edge N is visible on the outputs after edge N. There is no combinational bypass from In* to Out*.
- Count update:
  - push only: +1
  - pop only: -1
  - push and pop together: unchanged, both pointers advance
- Pointers wrap modulo DEPTH. Full/empty are resolved by Count, never by pointer equality alone.
- Flush (priority over push/pop): at the edge, both pointers = 0 and Count = 0.
  - Any same-cycle push is discarded. Any same-cycle pop is ignored.
  - OutValid = 0 and InReady = 1 from the next cycle.
- Reset asserted mid-operation: state clears immediately. Outputs are at reset values without waiting for Clk.
- Ordering: strict FIFO. Entries are never reordered, dropped (except by Flush or Reset) or duplicated.
- OutMisaligned is informational only. Misaligned entries are queued and popped normally.

Optional Feature:
- Macro: FETCHQ_STATS_EN.
- Defined: adds output StallCycles (32) and output FlushCount (16).
  - StallCycles increments on each cycle with InValid && !InReady.
  - FlushCount increments on each Flush edge.
  - Both saturate at all-ones and clear on Reset only; Flush does not clear them.
- Undefined: both ports and their counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then push PC=0x00,0x04,0x08 with OutReady=0 -> Count=3, InReady=1, OutPC=0x00, OutInstr matches the first instruction.
- Push 4 entries with OutReady=0 -> Count=4, InReady=0. A 5th push with InValid=1 is not accepted; the entry at OutPC stays 0x00.
- With the queue full, OutReady=1 and InValid=1 for one cycle -> pop only, Count=3. On the next cycle the push is accepted, Count=4. FIFO order 0x04,0x08,0x0C,0x10 holds across pointer wrap.
- 3 entries queued, assert Flush with InValid=1 and OutReady=1 -> after the edge Count=0, OutValid=0, OutPC=0, InReady=1, and the pushed entry is lost.
- Push InPC=0x06 -> OutMisaligned=1 at head. Assert Reset asynchronously between clock edges -> Count=0 and OutValid=0 immediately.
- With FETCHQ_STATS_EN: hold full with InValid=1 for 5 cycles and Flush twice -> StallCycles=5, FlushCount=2. Reset -> both read 0.

Source files
------------

// File: rtl/fetch_queue.sv
// ============================================================================
// fetch_queue
// ----------------------------------------------------------------------------
// Instruction prefetch queue sitting between the PC/instruction-memory fetch
// stage and decode. It buffers {PC, instruction} pairs and hands them to
// decode over a valid/ready handshake. The queue is first-word-fall-through:
// the head entry is presented on Out* as soon as it is written.
//
// Ports:
//   Clk            in   rising-edge clock
//   Reset          in   asynchronous, active-high reset
//   Flush          in   synchronous redirect; discards every queued entry
//   InValid        in   fetch side presents a PC/instruction pair
//   InPC[31:0]     in   PC of the fetched instruction
//   InInstr[31:0]  in   fetched instruction word
//   InReady        out  queue can accept an entry this cycle (Count < DEPTH)
//   OutValid       out  head entry is valid (Count != 0)
//   OutPC[31:0]    out  PC of head entry (0 when empty)
//   OutInstr[31:0] out  instruction of head entry (0 when empty)
//   OutMisaligned  out  head entry PC[1:0] != 0 (0 when empty)
//   OutReady       in   decode consumes the head entry this cycle
//   Count[AW:0]    out  current occupancy, 0..DEPTH
//
// Optional build macro FETCHQ_STATS_EN adds:
//   StallCycles[31:0] out  cycles with InValid && !InReady (saturating)
//   FlushCount[15:0]  out  number of Flush edges (saturating)
//   Both clear on Reset only.
//
// Parameters: DEPTH (power of two, >= 2) and AW = log2(DEPTH).
// ============================================================================
module fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Flush,
    input  logic          InValid,
    input  logic [31:0]   InPC,
    input  logic [31:0]   InInstr,
    output logic          InReady,
    output logic          OutValid,
    output logic [31:0]   OutPC,
    output logic [31:0]   OutInstr,
    output logic          OutMisaligned,
    input  logic          OutReady,
    output logic [AW:0]   Count
`ifdef FETCHQ_STATS_EN
    ,
    output logic [31:0]   StallCycles,
    output logic [15:0]   FlushCount
`endif
);

    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;

    // Storage is not reset; Count alone decides which slots are meaningful.
    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [DEPTH-1:0] mis_mem;

    logic in_ready;
    logic out_valid;
    logic push_en;
    logic pop_en;

    // Handshake qualifiers depend only on registered state, so there is no
    // combinational path from OutReady to InReady: a full queue that is
    // popped this cycle still refuses the push.
    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign push_en   = InValid  && in_ready;
    assign pop_en    = OutReady && out_valid;

    // ------------------------------------------------------------------------
    // Next-state logic. Flush overrides any same-cycle push or pop.
    // ------------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are exactly AW bits wide, so the natural overflow of
            // the increment gives the modulo-DEPTH wrap.
            if (push_en) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop_en) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            unique case ({push_en, pop_en})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Storage write. A push that coincides with Flush is dropped; writing the
    // slot anyway would be harmless, but gating keeps the intent obvious.
    // ------------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (push_en && !Flush) begin
            pc_mem[wr_ptr_q]    <= InPC;
            instr_mem[wr_ptr_q] <= InInstr;
            mis_mem[wr_ptr_q]   <= (InPC[1:0] != 2'b00);
        end
    end

    // ------------------------------------------------------------------------
    // Outputs: head entry falls through, forced to zero while empty.
    // ------------------------------------------------------------------------
    assign InReady       = in_ready;
    assign OutValid      = out_valid;
    assign OutPC         = out_valid ? pc_mem[rd_ptr_q]    : 32'h0;
    assign OutInstr      = out_valid ? instr_mem[rd_ptr_q] : 32'h0;
    assign OutMisaligned = out_valid ? mis_mem[rd_ptr_q]   : 1'b0;
    assign Count         = count_q;

`ifdef FETCHQ_STATS_EN
    // ------------------------------------------------------------------------
    // Statistics. Saturating counters, cleared by Reset only (Flush is a
    // normal pipeline event and must not erase the history it is counting).
    // ------------------------------------------------------------------------
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] flush_count_q,  flush_count_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (InValid && !in_ready && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (Flush && (flush_count_q != '1)) begin
            flush_count_d = flush_count_q + 16'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign StallCycles = stall_cycles_q;
    assign FlushCount  = flush_count_q;
`endif

endmodule
